// File: rtl/alu_issue_ctrl.sv
// Controller-side sequencer for the ALU: accepts reg-to-reg instructions, issues operands
// with a one-cycle En strobe, waits the ALU latency and writes ANS/FL back.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned NREG    = 16,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic              ext_we,
  input  logic [3:0]        ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [3:0]        opcode,
  output logic              En,
  input  logic [DATA_W-1:0] ANS,
  input  logic [3:0]        FL,
  output logic [3:0]        flags,
  output logic              done
);

  localparam int unsigned CNT_W = (ALU_LAT > 2) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [3:0]          opcode_q, opcode_d;
  logic                en_q, en_d;
  logic [3:0]          rd_q, rd_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [3:0]          flags_q, flags_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   regs_q [NREG];
  logic [DATA_W-1:0]   regs_d [NREG];

  // External preload wins over instruction acceptance
  assign instr_ready = (state_q == IDLE) && !ext_we;
  assign rd_data     = regs_q[rd_addr];
  assign A           = a_q;
  assign B           = b_q;
  assign opcode      = opcode_q;
  assign En          = en_q;
  assign flags       = flags_q;
  assign done        = done_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    opcode_d = opcode_q;
    rd_d     = rd_q;
    cnt_d    = cnt_q;
    flags_d  = flags_q;
    regs_d   = regs_q;
    en_d     = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (ext_we) begin
          regs_d[ext_addr] = ext_wdata;
        end else if (instr_valid) begin
          a_d      = regs_q[instr[7:4]];
          b_d      = regs_q[instr[3:0]];
          opcode_d = instr[15:12];
          rd_d     = instr[11:8];
          en_d     = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        if (ALU_LAT == 1) begin
          state_d = WB;
        end else begin
          cnt_d   = CNT_W'(ALU_LAT - 2);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = WB;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      WB: begin
        regs_d[rd_q] = ANS;
        flags_d      = FL;
        done_d       = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      opcode_q <= '0;
      en_q     <= 1'b0;
      rd_q     <= '0;
      cnt_q    <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      opcode_q <= opcode_d;
      en_q     <= en_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
      regs_q   <= regs_d;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: one ALU_LAT=1 and one ALU_LAT=3 instance driven by
// behavioural adder ALUs, with writebacks checked against a queue of predicted results.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ALU_LAT=1 instance signals
  logic v1, rdy1, we1, En1, dn1;
  logic [15:0] ins1;
  logic [3:0]  ea1, ra1, op1, fl1, flg1;
  logic [7:0]  ed1, rdd1, A1, B1, ans1;

  // ALU_LAT=3 instance signals
  logic v3, rdy3, we3, En3, dn3;
  logic [15:0] ins3;
  logic [3:0]  ea3, ra3, op3, flg3;
  logic [7:0]  ed3, rdd3, A3, B3, ans3, s1, s2;
  logic [3:0]  fl3 = 4'h0;

  alu_issue_ctrl #(.DATA_W(8), .NREG(16), .ALU_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .instr_valid(v1), .instr_ready(rdy1), .instr(ins1),
    .ext_we(we1), .ext_addr(ea1), .ext_wdata(ed1), .rd_addr(ra1), .rd_data(rdd1),
    .A(A1), .B(B1), .opcode(op1), .En(En1), .ANS(ans1), .FL(fl1), .flags(flg1), .done(dn1));

  alu_issue_ctrl #(.DATA_W(8), .NREG(16), .ALU_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .instr_valid(v3), .instr_ready(rdy3), .instr(ins3),
    .ext_we(we3), .ext_addr(ea3), .ext_wdata(ed3), .rd_addr(ra3), .rd_data(rdd3),
    .A(A3), .B(B3), .opcode(op3), .En(En3), .ANS(ans3), .FL(fl3), .flags(flg3), .done(dn3));

  // Adder ALU models: result registered on the edge that samples En
  always @(posedge clk) begin
    if (En1 && op1 == 4'h1) begin
      ans1 <= A1 + B1;
      fl1  <= 4'h0;
    end
    if (En3 && op3 == 4'h1) s1 <= A3 + B3;
    s2   <= s1;
    ans3 <= s2;
  end

  typedef struct packed {
    logic [3:0] rd;
    logic [7:0] val;
  } wb_t;

  wb_t        sb[$];
  logic [7:0] mreg1 [16];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Predict the writeback of an accepted add and queue it
  task automatic accept_model1(input logic [15:0] i);
    wb_t e;
    e.rd  = i[11:8];
    e.val = mreg1[i[7:4]] + mreg1[i[3:0]];
    mreg1[e.rd] = e.val;
    sb.push_back(e);
  endtask

  task automatic pop_check1(input string tag);
    wb_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      ra1 = e.rd;
      #1;
      chk(tag, rdd1, e.val);
      chk({tag, "_flags"}, flg1, 4'h0);
    end
  endtask

  task automatic wait_done1(input string tag);
    int n = 0;
    while (!dn1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!dn1) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else      pop_check1(tag);
  endtask

  task automatic preload1(input logic [3:0] a, input logic [7:0] d);
    we1 = 1'b1; ea1 = a; ed1 = d;
    #1 chk("ready_low_during_ext_we", rdy1, 1'b0);
    @(negedge clk);
    we1 = 1'b0;
    mreg1[a] = d;
  endtask

  task automatic issue1(input logic [15:0] i);
    v1 = 1'b1; ins1 = i;
    #1 chk("issue_ready", rdy1, 1'b1);
    accept_model1(i);
    @(negedge clk);
    v1 = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int enc;
    rst = 1'b1;
    v1 = 0; ins1 = 0; we1 = 0; ea1 = 0; ed1 = 0; ra1 = 0;
    v3 = 0; ins3 = 0; we3 = 0; ea3 = 0; ed3 = 0; ra3 = 0;
    for (int i = 0; i < 16; i++) mreg1[i] = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_A", A1, 8'h00);
    chk("rst_B", B1, 8'h00);
    chk("rst_opcode", op1, 4'h0);
    chk("rst_En", En1, 1'b0);
    chk("rst_flags", flg1, 4'h0);
    chk("rst_done", dn1, 1'b0);
    chk("rst_reg0", rdd1, 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // Preload r1=4, r2=3
    preload1(4'd1, 8'd4);
    preload1(4'd2, 8'd3);
    ra1 = 4'd1; #1 chk("preload_r1", rdd1, 8'd4);
    ra1 = 4'd2; #1 chk("preload_r2", rdd1, 8'd3);
    @(negedge clk);

    // Single add r3 = r1 + r2, cycle-by-cycle
    issue1(16'h1312);
    chk("single_A", A1, 8'd4);
    chk("single_B", B1, 8'd3);
    chk("single_opcode", op1, 4'h1);
    chk("single_En_issue", En1, 1'b1);
    chk("single_ready_issue", rdy1, 1'b0);
    @(negedge clk);
    chk("single_En_wb", En1, 1'b0);
    chk("single_ready_wb", rdy1, 1'b0);
    chk("single_done_early", dn1, 1'b0);
    @(negedge clk);
    chk("single_done", dn1, 1'b1);
    chk("single_ready_back", rdy1, 1'b1);
    pop_check1("single_r3");
    @(negedge clk);
    chk("single_done_one_cycle", dn1, 1'b0);

    // Back-to-back, rd==rs1: r3 = r3 + r2 twice, valid held high
    v1 = 1'b1; ins1 = 16'h1332;
    #1 chk("b2b_ready_first", rdy1, 1'b1);
    accept_model1(16'h1332);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy1 && n < 20);
    chk("b2b_accept_interval", n, 3);
    chk("b2b_done_first", dn1, 1'b1);
    pop_check1("b2b_r3_first");
    accept_model1(16'h1332);
    @(negedge clk);
    v1 = 1'b0;
    chk("b2b_En_second", En1, 1'b1);
    wait_done1("b2b_r3_second");
    @(negedge clk);

    // ext_we and instr_valid together: write wins, accept one cycle later
    we1 = 1'b1; ea1 = 4'd5; ed1 = 8'd9; v1 = 1'b1; ins1 = 16'h1512;
    #1 chk("coll_ready_low", rdy1, 1'b0);
    @(negedge clk);
    chk("coll_not_accepted", En1, 1'b0);
    mreg1[5] = 8'd9;
    ra1 = 4'd5; #1 chk("coll_ext_write", rdd1, 8'd9);
    we1 = 1'b0;
    #1 chk("coll_ready_after", rdy1, 1'b1);
    accept_model1(16'h1512);
    @(negedge clk);
    v1 = 1'b0;
    chk("coll_En", En1, 1'b1);
    chk("coll_A", A1, 8'd4);
    wait_done1("coll_r5");
    @(negedge clk);

    // Async reset during ISSUE discards the instruction
    v1 = 1'b1; ins1 = 16'h1312;
    @(negedge clk);
    v1 = 1'b0;
    chk("arst_En_before", En1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("arst_En", En1, 1'b0);
    chk("arst_A", A1, 8'h00);
    chk("arst_B", B1, 8'h00);
    chk("arst_flags", flg1, 4'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mreg1[i] = 8'h00;
    sb.delete();
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dn1) pulses++;
    end
    chk("arst_no_done", pulses, 0);
    ra1 = 4'd3; #1 chk("arst_no_write_r3", rdd1, 8'h00);
    preload1(4'd1, 8'd4);
    preload1(4'd2, 8'd3);
    @(negedge clk);
    issue1(16'h1312);
    wait_done1("arst_resume_r3");
    @(negedge clk);

    // ALU_LAT=3 instance: preload r1=4, r2=3, then add r4 = r1 + r2
    we3 = 1'b1; ea3 = 4'd1; ed3 = 8'd4;
    @(negedge clk);
    ea3 = 4'd2; ed3 = 8'd3;
    @(negedge clk);
    we3 = 1'b0;
    v3 = 1'b1; ins3 = 16'h1412;
    #1 chk("lat3_ready", rdy3, 1'b1);
    @(negedge clk);
    v3 = 1'b0;
    n = 1;
    enc = En3 ? 1 : 0;
    while (!dn3 && n < 20) begin
      @(negedge clk);
      n++;
      if (En3) enc++;
    end
    chk("lat3_done_latency", n, 5);
    chk("lat3_En_cycles", enc, 1);
    ra3 = 4'd4; #1 chk("lat3_r4", rdd3, 8'd7);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (dn3) pulses++;
    end
    chk("lat3_done_once", pulses, 0);
    chk("lat3_ready_idle", rdy3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
